// File: rtl/key_debounce_edge.sv
// Multi-channel pushbutton conditioner: 2-FF synchroniser, tick-based debounce, rise/fall pulses.
// Optional per-channel 8-bit press counters are enabled with the macro KEY_DEBOUNCE_PRESS_COUNT_EN.
module key_debounce_edge #(
    parameter int   N_CH         = 2,
    parameter int   PRESCALE     = 50000,
    parameter int   STABLE_TICKS = 10,
    parameter logic IDLE_LEVEL   = 1'b1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [N_CH-1:0]   btn_in,
    output logic              tick,
    output logic [N_CH-1:0]   level,
    output logic [N_CH-1:0]   rise,
    output logic [N_CH-1:0]   fall
`ifdef KEY_DEBOUNCE_PRESS_COUNT_EN
    ,
    output logic [8*N_CH-1:0] press_count
`endif
);

    localparam int PW = $clog2(PRESCALE);
    localparam int SW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] SCNT_LAST = SW'(STABLE_TICKS - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        pcnt_d = pcnt_q + PW'(1);
        tick_d = 1'b0;
        if (pcnt_q == PCNT_LAST) begin
            pcnt_d = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            pcnt_q <= '0;
            tick_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic          s1_q, s1_d, s2_q, s2_d;
        logic          level_q, level_d;
        logic          rise_q, rise_d, fall_q, fall_d;
        logic [SW-1:0] scnt_q, scnt_d;

        // The counter clears as soon as the input agrees again, so a glitch
        // never leaves a partial count behind for the next disturbance.
        always_comb begin
            s1_d    = btn_in[gi];
            s2_d    = s1_q;
            scnt_d  = scnt_q;
            level_d = level_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (s2_q == level_q) begin
                scnt_d = '0;
            end else if (tick_q) begin
                if (scnt_q == SCNT_LAST) begin
                    scnt_d  = '0;
                    level_d = s2_q;
                    rise_d  = s2_q;
                    fall_d  = ~s2_q;
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
        end

        always_ff @(posedge CLOCK_50) begin
            if (!reset) begin
                s1_q    <= IDLE_LEVEL;
                s2_q    <= IDLE_LEVEL;
                level_q <= IDLE_LEVEL;
                scnt_q  <= '0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                s1_q    <= s1_d;
                s2_q    <= s2_d;
                level_q <= level_d;
                scnt_q  <= scnt_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign level[gi] = level_q;
        assign rise[gi]  = rise_q;
        assign fall[gi]  = fall_q;

`ifdef KEY_DEBOUNCE_PRESS_COUNT_EN
        logic [7:0] pcount_q, pcount_d;

        // Counts the cycle after the registered fall pulse; wraps naturally at 8 bits.
        always_comb begin
            pcount_d = pcount_q + {7'd0, fall_q};
        end

        always_ff @(posedge CLOCK_50) begin
            if (!reset) begin
                pcount_q <= '0;
            end else begin
                pcount_q <= pcount_d;
            end
        end

        assign press_count[8*gi +: 8] = pcount_q;
`endif
    end

endmodule
